// File: rtl/accel_mem_responder.sv
// Memory-side responder for the accelerator memory port: serves accelerator reads/writes
// from a local word RAM after a fixed latency, plus a single-cycle host access port.
module accel_mem_responder #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DEPTH      = 1024,
    parameter int unsigned LATENCY    = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [1:0]            req_op,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_done,
    input  logic                  host_req,
    input  logic                  host_we,
    input  logic [ADDR_WIDTH-1:0] host_addr,
    input  logic [DATA_WIDTH-1:0] host_wdata,
    output logic [DATA_WIDTH-1:0] host_rdata,
    output logic                  host_ack,
    output logic                  err_oob,
    output logic                  err_op,
    output logic [15:0]           rd_count,
    output logic [15:0]           wr_count
);

    localparam int unsigned IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = 4;

    localparam logic [1:0] OP_NONE = 2'b00;
    localparam logic [1:0] OP_RD   = 2'b01;
    localparam logic [1:0] OP_RSV  = 2'b10;
    localparam logic [1:0] OP_WR   = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_RESP,
        ST_HOST
    } state_t;

    state_t                state;
    logic [1:0]            op_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [CW-1:0]         cnt;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic [1:0]            src_op_c;
    logic [ADDR_WIDTH-1:0] src_addr_c;
    logic [DATA_WIDTH-1:0] src_wdata_c;
    logic                  src_in_range_c;
    logic                  host_in_range_c;
    logic [IW-1:0]         src_idx_c;
    logic [IW-1:0]         host_idx_c;
    logic                  accept_c;
    logic                  enter_resp_c;
    logic                  enter_host_c;
    logic                  ram_we_c;
    logic [IW-1:0]         ram_waddr_c;
    logic [DATA_WIDTH-1:0] ram_wdata_c;

    // With LATENCY==1 the request goes straight from IDLE to RESP, so the live inputs
    // must be used on that edge; otherwise the latched copy is authoritative.
    always_comb begin
        src_op_c        = op_q;
        src_addr_c      = addr_q;
        src_wdata_c     = wdata_q;
        if (state == ST_IDLE) begin
            src_op_c    = req_op;
            src_addr_c  = req_addr;
            src_wdata_c = req_wdata;
        end
        src_in_range_c  = src_addr_c < ADDR_WIDTH'(DEPTH);
        host_in_range_c = host_addr < ADDR_WIDTH'(DEPTH);
        src_idx_c       = src_addr_c[IW-1:0];
        host_idx_c      = host_addr[IW-1:0];

        accept_c     = (state == ST_IDLE) && (req_op != OP_NONE);
        enter_resp_c = (accept_c && (LATENCY == 1)) ||
                       ((state == ST_WAIT) && (cnt == CW'(1)));
        enter_host_c = (state == ST_IDLE) && (req_op == OP_NONE) && host_req;
    end

    // Single RAM write port shared by accelerator and host; states make them exclusive.
    always_comb begin
        ram_we_c    = 1'b0;
        ram_waddr_c = src_idx_c;
        ram_wdata_c = src_wdata_c;
        if (reset) begin
            if (enter_resp_c && (src_op_c == OP_WR) && src_in_range_c) begin
                ram_we_c = 1'b1;
            end else if (enter_host_c && host_we && host_in_range_c) begin
                ram_we_c    = 1'b1;
                ram_waddr_c = host_idx_c;
                ram_wdata_c = host_wdata;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (ram_we_c) begin
            mem[ram_waddr_c] <= ram_wdata_c;
        end
    end

    // Control FSM with registered response outputs.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= ST_IDLE;
            op_q       <= OP_NONE;
            addr_q     <= '0;
            wdata_q    <= '0;
            cnt        <= '0;
            rsp_rdata  <= '0;
            rsp_done   <= 1'b0;
            host_rdata <= '0;
            host_ack   <= 1'b0;
            err_oob    <= 1'b0;
            err_op     <= 1'b0;
            rd_count   <= '0;
            wr_count   <= '0;
        end else begin
            rsp_done <= 1'b0;
            host_ack <= 1'b0;

            case (state)
                ST_IDLE: begin
                    if (accept_c) begin
                        op_q    <= req_op;
                        addr_q  <= req_addr;
                        wdata_q <= req_wdata;
                        cnt     <= CW'(LATENCY - 1);
                        state   <= (LATENCY == 1) ? ST_RESP : ST_WAIT;
                    end else if (host_req) begin
                        state <= ST_HOST;
                    end
                end
                ST_WAIT: begin
                    cnt <= cnt - CW'(1);
                    if (cnt == CW'(1)) begin
                        state <= ST_RESP;
                    end
                end
                ST_RESP: state <= ST_IDLE;
                ST_HOST: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase

            // Response side effects land on the edge entering RESP so they are visible in the done cycle.
            if (enter_resp_c) begin
                rsp_done <= 1'b1;
                case (src_op_c)
                    OP_RD: begin
                        rsp_rdata <= src_in_range_c ? mem[src_idx_c] : '0;
                        if (rd_count != 16'hFFFF) begin
                            rd_count <= rd_count + 16'd1;
                        end
                        if (!src_in_range_c) begin
                            err_oob <= 1'b1;
                        end
                    end
                    OP_WR: begin
                        if (wr_count != 16'hFFFF) begin
                            wr_count <= wr_count + 16'd1;
                        end
                        if (!src_in_range_c) begin
                            err_oob <= 1'b1;
                        end
                    end
                    OP_RSV:  err_op <= 1'b1;
                    default: ;
                endcase
            end

            if (enter_host_c) begin
                host_ack <= 1'b1;
                if (!host_we) begin
                    host_rdata <= host_in_range_c ? mem[host_idx_c] : '0;
                end
                if (!host_in_range_c) begin
                    err_oob <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_accel_mem_responder.sv
// Scoreboard bench for accel_mem_responder: drivers queue expected responses,
// a negedge monitor checks every rsp_done / host_ack against the queues.
module tb_accel_mem_responder;

    localparam int unsigned DW    = 32;
    localparam int unsigned AW    = 32;
    localparam int unsigned DEPTH = 1024;
    localparam int unsigned LAT   = 2;

    typedef struct {
        logic          chk;
        logic [DW-1:0] data;
        int            cyc;
    } exp_t;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic [1:0]    req_op = 2'b00;
    logic [AW-1:0] req_addr = '0;
    logic [DW-1:0] req_wdata = '0;
    logic [DW-1:0] rsp_rdata;
    logic          rsp_done;
    logic          host_req = 1'b0;
    logic          host_we = 1'b0;
    logic [AW-1:0] host_addr = '0;
    logic [DW-1:0] host_wdata = '0;
    logic [DW-1:0] host_rdata;
    logic          host_ack;
    logic          err_oob;
    logic          err_op;
    logic [15:0]   rd_count;
    logic [15:0]   wr_count;

    int   tests = 0;
    int   fails = 0;
    int   cyc   = 0;
    exp_t acc_q[$];
    exp_t host_q[$];

    accel_mem_responder #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEPTH), .LATENCY(LAT)
    ) dut (
        .clk(clk), .reset(reset),
        .req_op(req_op), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_rdata(rsp_rdata), .rsp_done(rsp_done),
        .host_req(host_req), .host_we(host_we), .host_addr(host_addr),
        .host_wdata(host_wdata), .host_rdata(host_rdata), .host_ack(host_ack),
        .err_oob(err_oob), .err_op(err_op),
        .rd_count(rd_count), .wr_count(wr_count)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: every done/ack must match the oldest queued expectation.
    always @(negedge clk) begin
        if (rsp_done) begin
            tests++;
            if (acc_q.size() == 0) begin
                fails++;
                $display("FAIL rsp_done: unexpected pulse at cycle %0d", cyc);
            end else begin
                exp_t e;
                e = acc_q.pop_front();
                if (rsp_rdata !== e.data || (e.cyc >= 0 && cyc != e.cyc)) begin
                    fails++;
                    $display("FAIL rsp: got data %h at cycle %0d, expected %h at cycle %0d",
                             rsp_rdata, cyc, e.data, e.cyc);
                end
            end
        end
        if (host_ack) begin
            tests++;
            if (host_q.size() == 0) begin
                fails++;
                $display("FAIL host_ack: unexpected pulse at cycle %0d", cyc);
            end else begin
                exp_t e;
                e = host_q.pop_front();
                if ((e.chk && host_rdata !== e.data) || (e.cyc >= 0 && cyc != e.cyc)) begin
                    fails++;
                    $display("FAIL host: got data %h at cycle %0d, expected %h at cycle %0d",
                             host_rdata, cyc, e.data, e.cyc);
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Returns in the cycle right after the done cycle (DUT back in IDLE).
    task automatic wait_done(input string name);
        bit seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (rsp_done) seen = 1'b1;
        end
        if (!seen) begin
            tests++;
            fails++;
            $display("FAIL %s: no rsp_done within 20 cycles", name);
        end
        step();
    endtask

    task automatic wait_ack(input string name);
        bit seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (host_ack) seen = 1'b1;
        end
        if (!seen) begin
            tests++;
            fails++;
            $display("FAIL %s: no host_ack within 20 cycles", name);
        end
        step();
    endtask

    // Issue one accelerator request in the current IDLE cycle; op is left driven.
    task automatic acc_req(input logic [1:0] op, input logic [AW-1:0] addr,
                           input logic [DW-1:0] wdata, input logic [DW-1:0] exp_data);
        acc_q.push_back('{chk: 1'b1, data: exp_data, cyc: cyc + int'(LAT)});
        req_op    = op;
        req_addr  = addr;
        req_wdata = wdata;
        wait_done("acc_req");
    endtask

    task automatic host_access(input logic we, input logic [AW-1:0] addr,
                               input logic [DW-1:0] wdata, input logic [DW-1:0] exp_data);
        host_q.push_back('{chk: !we, data: exp_data, cyc: -1});
        host_req   = 1'b1;
        host_we    = we;
        host_addr  = addr;
        host_wdata = wdata;
        wait_ack("host_access");
        host_req = 1'b0;
    endtask

    initial begin
        logic [DW-1:0] pre [4];
        pre[0] = 32'd4; pre[1] = 32'd4; pre[2] = 32'd2; pre[3] = 32'd2;

        repeat (3) step();
        reset = 1'b1;
        @(negedge clk);
        check("reset rsp_done", 32'(rsp_done), 32'd0);
        check("reset host_ack", 32'(host_ack), 32'd0);
        check("reset rsp_rdata", rsp_rdata, 32'd0);
        check("reset host_rdata", host_rdata, 32'd0);
        check("reset flags", {30'd0, err_oob, err_op}, 32'd0);
        check("reset counts", {rd_count, wr_count}, 32'd0);
        step();

        // Preload and back-to-back reads with op held at 01.
        for (int i = 0; i < 4; i++) host_access(1'b1, AW'(i + 1), pre[i], '0);
        for (int i = 0; i < 4; i++) acc_req(2'b01, AW'(i + 1), '0, pre[i]);
        req_op = 2'b00;
        @(negedge clk);
        check("rd_count after 4 reads", 32'(rd_count), 32'd4);
        step();

        // Write then host readback; rsp_rdata keeps the last read value.
        acc_req(2'b11, 32'd40, 32'hDEAD, 32'd2);
        req_op = 2'b00;
        host_access(1'b0, 32'd40, '0, 32'hDEAD);
        @(negedge clk);
        check("wr_count after write", 32'(wr_count), 32'd1);
        step();

        // Simultaneous accel and host: accel done at T+2, host ack at T+4.
        acc_q.push_back('{chk: 1'b1, data: 32'd2, cyc: cyc + 2});
        host_q.push_back('{chk: 1'b1, data: 32'd4, cyc: cyc + 4});
        req_op    = 2'b01;
        req_addr  = 32'd3;
        host_req  = 1'b1;
        host_we   = 1'b0;
        host_addr = 32'd1;
        wait_done("simul acc");
        req_op = 2'b00;
        wait_ack("simul host");
        host_req = 1'b0;

        // Out-of-range accesses.
        host_access(1'b1, 32'd0, 32'h1234, '0);
        @(negedge clk);
        check("err_oob before oob", 32'(err_oob), 32'd0);
        step();
        acc_req(2'b01, AW'(DEPTH + 5), '0, 32'd0);
        req_op = 2'b00;
        @(negedge clk);
        check("err_oob after oob read", 32'(err_oob), 32'd1);
        step();
        acc_req(2'b11, AW'(DEPTH), 32'h5555, 32'd0);
        req_op = 2'b00;
        host_access(1'b0, 32'd0, '0, 32'h1234);
        host_access(1'b0, 32'd2000, '0, 32'd0);
        @(negedge clk);
        check("err_op after oob", 32'(err_op), 32'd0);
        step();

        // Reset during WAIT discards the pending write.
        host_access(1'b1, 32'd7, 32'h77, '0);
        req_op    = 2'b11;
        req_addr  = 32'd7;
        req_wdata = 32'hBAD;
        step();
        reset  = 1'b0;
        req_op = 2'b00;
        repeat (2) step();
        reset = 1'b1;
        repeat (3) step();
        @(negedge clk);
        check("post-reset flags", {30'd0, err_oob, err_op}, 32'd0);
        check("post-reset counts", {rd_count, wr_count}, 32'd0);
        step();
        host_access(1'b0, 32'd7, '0, 32'h77);

        // Reserved op: one done, err_op set, counters unchanged.
        acc_req(2'b10, 32'd5, 32'hFFFF, 32'd0);
        req_op = 2'b00;
        @(negedge clk);
        check("err_op after op10", 32'(err_op), 32'd1);
        check("counts after op10", {rd_count, wr_count}, 32'd0);
        step();

        repeat (4) step();
        check("acc queue drained", 32'(acc_q.size()), 32'd0);
        check("host queue drained", 32'(host_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
